sum_operator_multi: RTL
=======================

Name: sum_operator_multi

Overview:
- Inverse of the multi-order difference stage: rebuilds the original sample frame from an ORDERS-th order finite-difference frame.
- Applies ORDERS cascaded running sums, one order per clock cycle.
- Keeps a per-order carry, the last row of each order from the previous frame, so reconstruction is continuous across frames.
- Sits on the recovery path, after reception of difference-coded frames and before downstream sample consumers.

Parameters:
- ROWS, default J+1: samples per frame.
- ORDERS, default N: difference order to undo; must be >= 1.
- STAGE_BITS, default $clog2(ORDERS+1): width of the order counter.
- OUT_RES (shared constant): sample width, signed two's complement.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  1  one-cycle frame strobe; in[] is valid this cycle.
- in  in  [ROWS] x OUT_RES signed  ORDERS-th order difference frame.
- busy  out  1  high while a frame is being integrated.
- out  out  [ROWS] x OUT_RES signed  reconstructed frame; held between frames.
- out_valid  out  1  one-cycle pulse when out updates.
- drop  out  1  sticky; set when en arrives while busy.

Behaviour:
- Reset values: out all 0, out_valid 0, busy 0, drop 0, accumulator all 0, carry[0..ORDERS-1] all 0, stage 0, state IDLE.
- Clock and reset are fixed: one clock (clk); reset is synchronous and active-high. Reset wins over every other input in the same cycle.
- States:
  - IDLE: on en, acc <= in, stage <= ORDERS, busy <= 1, go to RUN.
  - RUN: each cycle,
    - acc[i] <= carry[stage-1] + sum_{m=0..i} acc[m], computed combinationally over all rows.
    - carry[stage-1] <= new acc[ROWS-1].
    - stage <= stage-1.
    - When stage==1: out <= new acc, out_valid <= 1, busy <= 0, go to IDLE.
- Latency: en sampled at edge t; out and out_valid visible in cycle t+ORDERS+1.
- Throughput: one frame per ORDERS+1 cycles.
- en is accepted in the cycle out_valid is high, because busy is already 0.
- en while busy:
  - The frame is ignored; acc, carries and stage are unaffected.
  - drop <= 1 and stays 1 until reset.
- Arithmetic:
  - All adds are modulo 2^OUT_RES; no saturation.
  - Wrap-around is required so that the block is an exact inverse of the modular difference stage.
  - Prefix sums use OUT_RES-wide intermediates truncated at each step; this is equivalent to a single truncation mod 2^OUT_RES.
- Carries start at 0, i.e. history before the first frame is zero.
- Reset mid-RUN:
  - Aborts; out_valid never pulses for that frame.
  - Carries are cleared, so the next frame decodes as if it were the first.
- ORDERS==1: a single RUN cycle; latency 2.
- out is only written on completion, so it is stable while busy.

Decomposition:
- Shared package: sample_t (signed [OUT_RES-1:0]) and the constants OUT_RES, J, N, alongside the existing shared functions.
- Sub-module prefix_adder_row:
  - Purely combinational.
  - Inputs: carry_in and a ROWS-wide sample_t vector.
  - Output: the carry-in-seeded running sum.
  - The top level instantiates it once and multiplexes the carry by stage.

Test Plan:
All cases use ROWS=4 and OUT_RES=16 unless noted.
1. ORDERS=2, after reset, en with in={1,1,1,1} -> after one RUN cycle acc={1,2,3,4}; out={1,3,6,10}, out_valid in cycle t+3; busy high for cycles t+1..t+2.
2. Second frame {1,1,1,1}, applied in the out_valid cycle -> carries are 4 and 10; out={15,21,28,36}; no drop.
3. ORDERS=1, frames {32767,0,0,0} then {1,0,0,0} -> out={32767,32767,32767,32767}, then {-32768,-32768,-32768,-32768} (wrap).
4. ORDERS=2, en in cycle t+1 (busy) with {9,9,9,9} -> ignored; drop=1 and stays 1; out still {1,3,6,10}.
5. ORDERS=3, reset asserted in the second RUN cycle -> out stays 0, no out_valid pulse; a following frame {1,0,0,0} gives out={1,3,6,10}.
6. ORDERS=N, ROWS=J+1, 200 random frames -> out matches a golden model of modular N-fold cumulative sum with zero initial history, bit-exact every frame.

Source files
------------

// File: rtl/sum_operator_multi_pkg.sv
// Shared types and constants for the multi-order running-sum reconstruction path.
// Sample arithmetic is modulo 2^OUT_RES so it exactly undoes the modular difference stage.
package sum_operator_multi_pkg;

  localparam int OUT_RES = 16;
  localparam int J       = 3;
  localparam int N       = 2;

  typedef logic signed [OUT_RES-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Wrapping add: the result is truncated to the sample width, never saturated.
  function automatic sample_t add_mod(input sample_t a, input sample_t b);
    return sample_t'(a + b);
  endfunction

endpackage

// File: rtl/sum_operator_multi_prefix_adder_row.sv
// Combinational running sum over one frame, seeded by the carry from the previous frame.
module prefix_adder_row
  import sum_operator_multi_pkg::*;
#(
  parameter int ROWS = J + 1
) (
  input  sample_t carry_in,
  input  sample_t row_in  [ROWS],
  output sample_t row_out [ROWS]
);

  sample_t run_sum;

  always_comb begin
    run_sum = carry_in;
    for (int i = 0; i < ROWS; i++) begin
      run_sum    = add_mod(run_sum, row_in[i]);
      row_out[i] = run_sum;
    end
  end

endmodule

// File: rtl/sum_operator_multi.sv
// Undoes an ORDERS-th order finite difference, one running-sum order per clock,
// carrying the last row of each order across frames so decoding is continuous.
module sum_operator_multi
  import sum_operator_multi_pkg::*;
#(
  parameter int ROWS       = J + 1,
  parameter int ORDERS     = N,
  parameter int STAGE_BITS = $clog2(ORDERS + 1)
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  sample_t in        [ROWS],
  output logic    busy,
  output sample_t out       [ROWS],
  output logic    out_valid,
  output logic    drop
);

  state_t                state_q;
  logic [STAGE_BITS-1:0] stage_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic                  drop_q;
  sample_t               acc_q   [ROWS];
  sample_t               out_q   [ROWS];
  sample_t               carry_q [ORDERS];

  sample_t carry_sel;
  sample_t acc_d [ROWS];

  // Stage counts down from ORDERS to 1; order k+1 uses carry slot k.
  always_comb begin
    carry_sel = '0;
    for (int k = 0; k < ORDERS; k++) begin
      if (stage_q == STAGE_BITS'(k + 1)) carry_sel = carry_q[k];
    end
  end

  prefix_adder_row #(
    .ROWS(ROWS)
  ) u_prefix (
    .carry_in(carry_sel),
    .row_in  (acc_q),
    .row_out (acc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        acc_q[i] <= '0;
        out_q[i] <= '0;
      end
      for (int k = 0; k < ORDERS; k++) carry_q[k] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            acc_q   <= in;
            stage_q <= STAGE_BITS'(ORDERS);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A frame arriving mid-integration is discarded, only flagged.
          if (en) drop_q <= 1'b1;
          acc_q   <= acc_d;
          stage_q <= stage_q - STAGE_BITS'(1);
          for (int k = 0; k < ORDERS; k++) begin
            if (stage_q == STAGE_BITS'(k + 1)) carry_q[k] <= acc_d[ROWS-1];
          end
          if (stage_q == STAGE_BITS'(1)) begin
            out_q       <= acc_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign drop      = drop_q;

endmodule
